// File: rtl/pktctrl_rd_fmt.sv
// Capture-buffer read formatter: fetches 36-bit words with fixed read latency
// and streams them out as contiguous 18-bit half-words toward the ADC pads.
module pktctrl_rd_fmt #(
   parameter int unsigned ADDR_W     = 12,
   parameter int unsigned RD_LAT     = 2,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              rf_rd_start,
   input  logic              rf_rd_abort,
   input  logic [ADDR_W-1:0] rf_rd_base_addr,
   input  logic [ADDR_W:0]   rf_rd_len,
   input  logic              rf_rd_order,
   output logic              mem_rd_en,
   output logic [ADDR_W-1:0] mem_rd_addr,
   input  logic [35:0]       mem_rd_data,
   output logic [17:0]       adc_data,
   output logic              adc_data_valid,
   output logic              rd_busy,
   output logic              rd_done,
   output logic              rd_aborted
);

   localparam int unsigned PW = $clog2(FIFO_DEPTH);
   localparam int unsigned CW = PW + 1;
   localparam int unsigned LW = ADDR_W + 1;

   typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_e;

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   base_q, base_d;
   logic [LW-1:0]       len_q, len_d;
   logic                order_q, order_d;
   logic [LW-1:0]       issued_q, issued_d;
   logic [LW-1:0]       sent_q, sent_d;
   logic                half_q, half_d;
   logic [RD_LAT-1:0]   infl_q, infl_d;
   logic [2:0]          flush_q, flush_d;
   logic [PW-1:0]       wr_q, wr_d;
   logic [PW-1:0]       rd_q, rd_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic                en_q, en_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [17:0]         data_q, data_d;
   logic                valid_q, valid_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                abrt_q, abrt_d;
   logic [35:0]         fifo_q [FIFO_DEPTH];
   logic                push, pop;
   logic [7:0]          outst;
   logic [35:0]         head;

   assign head = fifo_q[rd_q];

   always_comb begin
      state_d  = state_q;
      base_d   = base_q;
      len_d    = len_q;
      order_d  = order_q;
      issued_d = issued_q;
      sent_d   = sent_q;
      half_d   = half_q;
      flush_d  = flush_q;
      wr_d     = wr_q;
      rd_d     = rd_q;
      cnt_d    = cnt_q;
      addr_d   = addr_q;
      busy_d   = busy_q;
      abrt_d   = abrt_q;
      en_d     = 1'b0;
      data_d   = '0;
      valid_d  = 1'b0;
      done_d   = 1'b0;
      push     = 1'b0;
      pop      = 1'b0;
      infl_d[0] = en_q;
      for (int i = 1; i < RD_LAT; i++) infl_d[i] = infl_q[i-1];
      // Credit: words buffered plus every read not yet returned.
      outst = 8'(cnt_q) + 8'(en_q);
      for (int i = 0; i < RD_LAT; i++) outst = outst + 8'(infl_q[i]);

      unique case (state_q)
         IDLE: begin
            if (rf_rd_start) begin
               abrt_d = 1'b0;
               if (rf_rd_len != '0) begin
                  base_d   = rf_rd_base_addr;
                  len_d    = rf_rd_len;
                  order_d  = rf_rd_order;
                  en_d     = 1'b1;
                  addr_d   = rf_rd_base_addr;
                  issued_d = LW'(1);
                  sent_d   = '0;
                  half_d   = 1'b0;
                  wr_d     = '0;
                  rd_d     = '0;
                  cnt_d    = '0;
                  busy_d   = 1'b1;
                  state_d  = RUN;
               end else begin
                  done_d = 1'b1;
               end
            end
         end
         RUN: begin
            if (rf_rd_abort) begin
               cnt_d   = '0;
               wr_d    = '0;
               rd_d    = '0;
               half_d  = 1'b0;
               flush_d = '0;
               state_d = FLUSH;
            end else if (sent_q == len_q) begin
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = IDLE;
            end else begin
               push = infl_q[RD_LAT-1];
               if (issued_q < len_q && outst < 8'(FIFO_DEPTH)) begin
                  en_d     = 1'b1;
                  addr_d   = base_q + issued_q[ADDR_W-1:0];
                  issued_d = issued_q + LW'(1);
               end
               if (cnt_q != '0) begin
                  valid_d = 1'b1;
                  data_d  = (half_q ^ order_q) ? head[17:0] : head[35:18];
                  half_d  = ~half_q;
                  if (half_q) begin
                     pop    = 1'b1;
                     rd_d   = rd_q + PW'(1);
                     sent_d = sent_q + LW'(1);
                  end
               end
               if (push) wr_d = wr_q + PW'(1);
               cnt_d = cnt_q + CW'(push) - CW'(pop);
            end
         end
         FLUSH: begin
            if (flush_q == 3'(RD_LAT - 1)) begin
               done_d  = 1'b1;
               abrt_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = IDLE;
            end else begin
               flush_d = flush_q + 3'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q  <= IDLE;
         base_q   <= '0;
         len_q    <= '0;
         order_q  <= 1'b0;
         issued_q <= '0;
         sent_q   <= '0;
         half_q   <= 1'b0;
         infl_q   <= '0;
         flush_q  <= '0;
         wr_q     <= '0;
         rd_q     <= '0;
         cnt_q    <= '0;
         en_q     <= 1'b0;
         addr_q   <= '0;
         data_q   <= '0;
         valid_q  <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         abrt_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         base_q   <= base_d;
         len_q    <= len_d;
         order_q  <= order_d;
         issued_q <= issued_d;
         sent_q   <= sent_d;
         half_q   <= half_d;
         infl_q   <= infl_d;
         flush_q  <= flush_d;
         wr_q     <= wr_d;
         rd_q     <= rd_d;
         cnt_q    <= cnt_d;
         en_q     <= en_d;
         addr_q   <= addr_d;
         data_q   <= data_d;
         valid_q  <= valid_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         abrt_q   <= abrt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) fifo_q[wr_q] <= mem_rd_data;
   end

   assign mem_rd_en      = en_q;
   assign mem_rd_addr    = addr_q;
   assign adc_data       = data_q;
   assign adc_data_valid = valid_q;
   assign rd_busy        = busy_q;
   assign rd_done        = done_q;
   assign rd_aborted     = abrt_q;

endmodule

// File: tb/tb_pktctrl_rd_fmt.sv
// Bench for pktctrl_rd_fmt: vector table of transfers plus abort and
// reset sequences, with address and half-word scoreboards.
module tb_pktctrl_rd_fmt;

   localparam int AW  = 12;
   localparam int LAT = 2;
   localparam int DEP = 4;

   typedef struct {
      logic [AW-1:0] base;
      logic [AW:0]   len;
      logic          ord;
      logic          abt;
      int            mid;
      int            first;
      int            donek;
   } vec_t;

   logic          clk = 1'b0;
   logic          rstn = 1'b0;
   logic          start = 1'b0;
   logic          abort = 1'b0;
   logic [AW-1:0] base = '0;
   logic [AW:0]   len = '0;
   logic          order = 1'b0;
   logic          en;
   logic [AW-1:0] addr;
   logic [35:0]   rdata;
   logic [17:0]   dout;
   logic          dval, busy, done, abrtd;

   int nvec = 0;
   int nerr = 0;

   logic [17:0]   expq [$];
   logic [AW-1:0] aq [$];
   logic [AW-1:0] pa [LAT];

   always #5 clk = ~clk;

   pktctrl_rd_fmt #(.ADDR_W(AW), .RD_LAT(LAT), .FIFO_DEPTH(DEP)) dut (
      .clk(clk), .rstn(rstn),
      .rf_rd_start(start), .rf_rd_abort(abort),
      .rf_rd_base_addr(base), .rf_rd_len(len), .rf_rd_order(order),
      .mem_rd_en(en), .mem_rd_addr(addr), .mem_rd_data(rdata),
      .adc_data(dout), .adc_data_valid(dval),
      .rd_busy(busy), .rd_done(done), .rd_aborted(abrtd)
   );

   function automatic logic [35:0] mk(input logic [AW-1:0] a);
      return {a, ~a, a ^ 12'h5A5};
   endfunction

   // Buffer model: address sampled with the strobe, data RD_LAT edges later.
   always @(posedge clk) begin
      pa[0] <= addr;
      for (int i = 1; i < LAT; i++) pa[i] <= pa[i-1];
   end
   assign rdata = mk(pa[LAT-1]);

   task automatic chk(input string nm, input logic [35:0] act,
                      input logic [35:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   task automatic unexp(input string nm, input logic [35:0] act);
      nvec++;
      nerr++;
      $display("FAIL %s: got %0h, expected nothing", nm, act);
   endtask

   always @(negedge clk) begin
      if (rstn) begin
         if (en) begin
            if (aq.size() == 0) unexp("unexp_read", 36'(addr));
            else chk("rd_addr", 36'(addr), 36'(aq.pop_front()));
         end
         if (dval) begin
            if (expq.size() == 0) unexp("unexp_valid", 36'(dout));
            else chk("adc_data", 36'(dout), 36'(expq.pop_front()));
         end else begin
            chk("adc_idle_zero", 36'(dout), 36'(0));
         end
      end
   end

   task automatic load(input logic [AW-1:0] b, input logic [AW:0] l,
                       input logic o);
      logic [AW-1:0] a;
      logic [35:0]   d;
      for (int w = 0; w < int'(l); w++) begin
         a = b + AW'(w);
         d = mk(a);
         aq.push_back(a);
         if (o) begin
            expq.push_back(d[17:0]);
            expq.push_back(d[35:18]);
         end else begin
            expq.push_back(d[35:18]);
            expq.push_back(d[17:0]);
         end
      end
   endtask

   task automatic run_vec(input vec_t v);
      int first = -1;
      int dk = -1;
      int nval = 0;
      int nb = 0;
      load(v.base, v.len, v.ord);
      base = v.base;
      len = v.len;
      order = v.ord;
      start = 1'b1;
      abort = v.abt;
      for (int k = 0; k < 60 && dk < 0; k++) begin
         @(negedge clk); #2;
         if (k == 0) begin
            start = 1'b0;
            abort = 1'b0;
         end
         if (k == v.mid) begin
            start = 1'b1;
            len = 13'd5;
            base = 12'h700;
         end
         if (k == v.mid + 1) start = 1'b0;
         if (dval) begin
            nval++;
            if (first < 0) first = k;
         end
         if (busy) nb++;
         if (done) dk = k;
      end
      chk("first_valid_k", 36'(first), 36'(v.first));
      chk("done_k", 36'(dk), 36'(v.donek));
      chk("valid_cnt", 36'(nval), 36'(2 * int'(v.len)));
      chk("busy_cycles", 36'(nb), 36'((v.len == 0) ? 0 : v.donek));
      chk("aborted_clear", 36'(abrtd), 36'(0));
      chk("words_left", 36'(expq.size()), 36'(0));
      @(negedge clk); #2;
      chk("done_pulse", 36'(done), 36'(0));
   endtask

   vec_t tbl [6];

   initial begin
      int nval;
      #500000;
      $display("FAIL watchdog: time %0t, expected completion", $time);
      $fatal(1);
      nval = 0;
   end

   initial begin
      int nval;
      tbl[0] = '{12'h010, 13'd4, 1'b0, 1'b0, -1, 4, 12};
      tbl[1] = '{12'h000, 13'd0, 1'b0, 1'b0, -1, -1, 0};
      tbl[2] = '{12'hFFE, 13'd4, 1'b0, 1'b0, -1, 4, 12};
      tbl[3] = '{12'h123, 13'd7, 1'b1, 1'b1, -1, 4, 18};
      tbl[4] = '{12'h3FF, 13'd1, 1'b0, 1'b0, -1, 4, 6};
      tbl[5] = '{12'h020, 13'd2, 1'b1, 1'b0, 5, 4, 8};

      repeat (2) @(negedge clk);
      #2;
      chk("rst_valid", 36'(dval), 36'(0));
      chk("rst_en", 36'(en), 36'(0));
      chk("rst_busy", 36'(busy), 36'(0));
      chk("rst_done", 36'(done), 36'(0));
      rstn = 1'b1;
      repeat (2) @(negedge clk);
      #2;

      for (int i = 0; i < 6; i++) run_vec(tbl[i]);

      // Abort after three half-words.
      load(12'h200, 13'd4, 1'b0);
      base = 12'h200;
      len = 13'd4;
      order = 1'b0;
      start = 1'b1;
      nval = 0;
      for (int k = 0; k <= 10; k++) begin
         @(negedge clk); #2;
         if (k == 0) start = 1'b0;
         if (k <= 6 && dval) nval++;
         if (k == 6) begin
            chk("abort_pre_cnt", 36'(nval), 36'(3));
            abort = 1'b1;
            expq.delete();
         end
         if (k == 7) begin
            abort = 1'b0;
            chk("abort_valid_off", 36'(dval), 36'(0));
            chk("flush_busy", 36'(busy), 36'(1));
         end
         if (k == 8) chk("flush_no_done", 36'(done), 36'(0));
         if (k == 9) begin
            chk("abort_done", 36'(done), 36'(1));
            chk("abort_flag", 36'(abrtd), 36'(1));
            chk("abort_busy_off", 36'(busy), 36'(0));
         end
         if (k == 10) begin
            chk("abort_done_pulse", 36'(done), 36'(0));
            chk("abort_flag_held", 36'(abrtd), 36'(1));
            abort = 1'b1;
         end
      end
      @(negedge clk); #2;
      abort = 1'b0;
      repeat (2) @(negedge clk);
      #2;
      chk("idle_abort_done", 36'(done), 36'(0));
      chk("idle_abort_busy", 36'(busy), 36'(0));
      chk("idle_abort_flag", 36'(abrtd), 36'(1));
      run_vec('{12'h040, 13'd2, 1'b0, 1'b0, -1, 4, 8});

      // Reset in the middle of a transfer.
      load(12'h500, 13'd4, 1'b0);
      base = 12'h500;
      len = 13'd4;
      start = 1'b1;
      for (int k = 0; k <= 5; k++) begin
         @(negedge clk); #2;
         if (k == 0) start = 1'b0;
      end
      chk("pre_rst_valid", 36'(dval), 36'(1));
      rstn = 1'b0;
      #1;
      chk("arst_valid", 36'(dval), 36'(0));
      chk("arst_data", 36'(dout), 36'(0));
      chk("arst_en", 36'(en), 36'(0));
      chk("arst_addr", 36'(addr), 36'(0));
      chk("arst_busy", 36'(busy), 36'(0));
      chk("arst_done", 36'(done), 36'(0));
      expq.delete();
      aq.delete();
      @(negedge clk); #2;
      rstn = 1'b1;
      repeat (3) @(negedge clk);
      #2;
      chk("post_rst_busy", 36'(busy), 36'(0));
      chk("post_rst_done", 36'(done), 36'(0));
      chk("post_rst_valid", 36'(dval), 36'(0));
      run_vec(tbl[0]);

      @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
